// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the decode-side hazard controller: interrupt
// sequencer state encoding, default register-address width and the
// stack-write strobe encoding used by decode and control logic.
package pipe_hazard_ctrl_pkg;

   localparam int REG_AW_DEF = 3;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_DRAIN      = 3'd1,
      ST_PUSH_PC    = 3'd2,
      ST_PUSH_FLAGS = 3'd3,
      ST_VECTOR     = 3'd4
   } int_state_e;

   // Stack-write strobe encoding: bit 0 writes the PC, bit 1 writes flags.
   localparam logic [1:0] STK_NONE  = 2'b00;
   localparam logic [1:0] STK_PC    = 2'b01;
   localparam logic [1:0] STK_FLAGS = 2'b10;

   function automatic logic [1:0] stack_strobe(input int_state_e s);
      case (s)
         ST_PUSH_PC:    return STK_PC;
         ST_PUSH_FLAGS: return STK_FLAGS;
         default:       return STK_NONE;
      endcase
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_int_seq.sv
// Interrupt entry sequencer: IDLE -> DRAIN -> PUSH_PC -> PUSH_FLAGS ->
// VECTOR -> IDLE, plus the pending-request latch. int1 beats int2 both
// at acceptance and among pending requests. A request that loses the
// arbitration at acceptance, or arrives while a sequence runs, is kept
// pending and taken from IDLE after the current sequence finishes.
module int_seq_fsm
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       int1,
   input  logic       int2,
   output int_state_e state,
   output logic       vec_sel
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   int_state_e    state_q, state_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic          sel_q, sel_d;
   logic          pend1_q, pend1_d;
   logic          pend2_q, pend2_d;
   logic          req1, req2;

   assign req1 = int1 | pend1_q;
   assign req2 = int2 | pend2_q;

   // State, drain counter, vector select and pending latch registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sel_q   <= 1'b0;
         pend1_q <= 1'b0;
         pend2_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         pend1_q <= pend1_d;
         pend2_q <= pend2_d;
      end
   end

   // Next-state, drain countdown and pending-request bookkeeping.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      pend1_d = pend1_q | int1;
      pend2_d = pend2_q | int2;
      case (state_q)
         ST_IDLE: begin
            pend1_d = pend1_q;
            pend2_d = pend2_q;
            if (req1 | req2) begin
               state_d = ST_DRAIN;
               cnt_d   = DW'(DRAIN_CYCLES - 1);
               sel_d   = ~req1;
               if (req1) begin
                  pend1_d = 1'b0;
                  pend2_d = req2;
               end else begin
                  pend2_d = 1'b0;
               end
            end
         end
         ST_DRAIN: begin
            if (cnt_q == '0) state_d = ST_PUSH_PC;
            else             cnt_d   = cnt_q - DW'(1);
         end
         ST_PUSH_PC:    state_d = ST_PUSH_FLAGS;
         ST_PUSH_FLAGS: state_d = ST_VECTOR;
         ST_VECTOR:     state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
   end

   assign state   = state_q;
   assign vec_sel = sel_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-side pipeline hazard controller: load-use stall, taken-branch
// flush and interrupt entry sequencing for the IF/ID and ID/EX registers.
// Optional macro HAZARD_STATS_EN adds saturating stall/flush counters;
// without it stall_cnt and flush_cnt are tied to zero.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW       = REG_AW_DEF,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_rs_used,
   input  logic              id_rd_used,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              branch_taken,
   input  logic              int1,
   input  logic              int2,
   output logic              pc_stall,
   output logic              fd_stall,
   output logic              de_bubble,
   output logic              fd_flush,
   output logic              int_busy,
   output logic              int_push_pc,
   output logic              int_push_flags,
   output logic              int_vec_load,
   output logic              int_vec_sel,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   int_state_e seq_state;
   logic       seq_sel;
   logic       busy;
   logic       seq_hold;
   logic       in_vector;
   logic       hz;
   logic       hz_stall;
   logic [1:0] stk;

   int_seq_fsm #(
      .DRAIN_CYCLES (DRAIN_CYCLES)
   ) u_int_seq (
      .clk     (clk),
      .reset   (reset),
      .int1    (int1),
      .int2    (int2),
      .state   (seq_state),
      .vec_sel (seq_sel)
   );

   // Decode the sequencer state and the load-use hazard (masked while an
   // interrupt sequence owns the pipeline; a taken branch cancels the stall).
   always_comb begin
      busy      = (seq_state != ST_IDLE);
      in_vector = (seq_state == ST_VECTOR);
      seq_hold  = busy & ~in_vector;
      stk       = stack_strobe(seq_state);
      hz        = ex_mem_read & ~busy &
                  ((id_rs_used & (id_rs == ex_rd)) | (id_rd_used & (id_rd == ex_rd)));
      hz_stall  = hz & ~branch_taken;
   end

   // Pipeline-register controls; everything is forced low while reset is held.
   always_comb begin
      pc_stall       = 1'b0;
      fd_stall       = 1'b0;
      de_bubble      = 1'b0;
      fd_flush       = 1'b0;
      int_busy       = 1'b0;
      int_push_pc    = 1'b0;
      int_push_flags = 1'b0;
      int_vec_load   = 1'b0;
      int_vec_sel    = 1'b0;
      if (reset) begin
         pc_stall       = hz_stall | seq_hold;
         fd_stall       = hz_stall | seq_hold;
         de_bubble      = hz | branch_taken | busy;
         fd_flush       = branch_taken | in_vector;
         int_busy       = busy;
         int_push_pc    = stk[0];
         int_push_flags = stk[1];
         int_vec_load   = in_vector;
         int_vec_sel    = in_vector & seq_sel;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;

   // Saturating counts of load-use stall cycles and taken-branch cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (hz_stall && (stall_q != '1))     stall_q <= stall_q + CNT_W'(1);
         if (branch_taken && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. The reference model tracks the
// interrupt sequence as a cycle position inside a DRAIN_CYCLES+3 window
// plus two pending flags, and derives every expected output from that.
module tb_pipe_hazard_ctrl;

   localparam int D  = 3;
   localparam int CW = 2;
   localparam int AW = 3;
   localparam int SAT = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [AW-1:0] id_rs = '0, id_rd = '0, ex_rd = '0;
   logic          id_rs_used = 1'b0, id_rd_used = 1'b0, ex_mem_read = 1'b0;
   logic          branch_taken = 1'b0, int1 = 1'b0, int2 = 1'b0;

   logic          pc_stall, fd_stall, de_bubble, fd_flush, int_busy;
   logic          int_push_pc, int_push_flags, int_vec_load, int_vec_sel;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic [8:0]    obs;

   int checks = 0;
   int errors = 0;

   // model state: pos 0 = idle, 1..D drain, D+1 push pc, D+2 push flags, D+3 vector
   int pos = 0;
   bit m_p1 = 0, m_p2 = 0, m_sel = 0;
   int m_stall = 0, m_flush = 0;

   pipe_hazard_ctrl #(
      .REG_AW (AW), .DRAIN_CYCLES (D), .CNT_W (CW)
   ) dut (
      .clk (clk), .reset (reset),
      .id_rs (id_rs), .id_rd (id_rd), .id_rs_used (id_rs_used), .id_rd_used (id_rd_used),
      .ex_mem_read (ex_mem_read), .ex_rd (ex_rd), .branch_taken (branch_taken),
      .int1 (int1), .int2 (int2),
      .pc_stall (pc_stall), .fd_stall (fd_stall), .de_bubble (de_bubble), .fd_flush (fd_flush),
      .int_busy (int_busy), .int_push_pc (int_push_pc), .int_push_flags (int_push_flags),
      .int_vec_load (int_vec_load), .int_vec_sel (int_vec_sel),
      .stall_cnt (stall_cnt), .flush_cnt (flush_cnt)
   );

   assign obs = {pc_stall, fd_stall, de_bubble, fd_flush, int_busy,
                 int_push_pc, int_push_flags, int_vec_load, int_vec_sel};

   always #5 clk = ~clk;

   function automatic bit model_hz();
      return (pos == 0) && ex_mem_read &&
             ((id_rs_used && id_rs == ex_rd) || (id_rd_used && id_rd == ex_rd));
   endfunction

   function automatic logic [8:0] model_out();
      bit busy, hz, br, hold;
      if (!reset) return 9'd0;
      busy = (pos != 0);
      hz   = model_hz();
      br   = branch_taken;
      hold = (pos >= 1) && (pos <= D + 2);
      return {(hz && !br) || hold, (hz && !br) || hold, hz || br || busy,
              br || (pos == D + 3), busy, pos == D + 1, pos == D + 2,
              pos == D + 3, (pos == D + 3) && m_sel};
   endfunction

   function automatic logic [2*CW-1:0] model_cnts();
`ifdef HAZARD_STATS_EN
      return {CW'(m_stall), CW'(m_flush)};
`else
      return '0;
`endif
   endfunction

   task automatic model_step();
      bit hz;
      if (!reset) begin
         pos = 0; m_p1 = 0; m_p2 = 0; m_sel = 0; m_stall = 0; m_flush = 0;
         return;
      end
      hz = model_hz();
      if (hz && !branch_taken) m_stall = (m_stall >= SAT) ? SAT : m_stall + 1;
      if (branch_taken)        m_flush = (m_flush >= SAT) ? SAT : m_flush + 1;
      if (pos == 0) begin
         if (int1 || int2 || m_p1 || m_p2) begin
            if (int1 || m_p1) begin
               m_sel = 0; m_p1 = 0; m_p2 = m_p2 || int2;
            end else begin
               m_sel = 1; m_p2 = 0;
            end
            pos = 1;
         end
      end else begin
         m_p1 = m_p1 || int1;
         m_p2 = m_p2 || int2;
         pos  = (pos == D + 3) ? 0 : pos + 1;
      end
   endtask

   task automatic advance();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_rs = '0; id_rd = '0; ex_rd = '0;
      id_rs_used = 0; id_rd_used = 0; ex_mem_read = 0;
      branch_taken = 0; int1 = 0; int2 = 0;
   endtask

   task automatic test_reset();
      logic [8:0] exp;
      reset = 0;
      ex_mem_read = 1; ex_rd = 3; id_rs = 3; id_rs_used = 1; branch_taken = 1; int1 = 1;
      #2;
      exp = 9'd0;
      checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL reset_outputs: got %b want %b", obs, exp);
      end
      checks++;
      if ({stall_cnt, flush_cnt} !== '0) begin
         errors++; $display("FAIL reset_counters: got %h want 0", {stall_cnt, flush_cnt});
      end
      clear_inputs();
      advance();
      reset = 1;
      @(negedge clk);
      exp = model_out();
      checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL reset_release: got %b want %b", obs, exp);
      end
      advance();
   endtask

   task automatic test_load_use();
      logic [8:0] exp;
      clear_inputs();
      ex_mem_read = 1; ex_rd = 3; id_rs = 3; id_rs_used = 1;
      @(negedge clk);
      exp = model_out();
      checks++;
      if (obs !== exp || obs[8:6] !== 3'b111) begin
         errors++; $display("FAIL load_use_stall: got %b want %b", obs, exp);
      end
      advance();
      clear_inputs();
      @(negedge clk);
      exp = model_out();
      checks++;
      if (obs !== exp || obs[8:6] !== 3'b000) begin
         errors++; $display("FAIL load_use_release: got %b want %b", obs, exp);
      end
      advance();
   endtask

   task automatic test_branch();
      logic [8:0] exp;
      clear_inputs();
      ex_mem_read = 1; ex_rd = 3; id_rs = 3; id_rs_used = 0; id_rd = 5; id_rd_used = 1;
      @(negedge clk);
      exp = model_out();
      checks++;
      if (obs !== exp || obs !== 9'd0) begin
         errors++; $display("FAIL no_hazard: got %b want %b", obs, exp);
      end
      advance();
      id_rs_used = 1; branch_taken = 1;
      @(negedge clk);
      exp = model_out();
      checks++;
      if (obs !== exp || obs[8:5] !== 4'b0011) begin
         errors++; $display("FAIL branch_override: got %b want %b", obs, exp);
      end
      advance();
      clear_inputs();
   endtask

   task automatic test_int2_seq();
      logic [8:0] exp;
      int nvec = 0;
      clear_inputs();
      int2 = 1;
      for (int i = 0; i < D + 6; i++) begin
         @(negedge clk);
         exp = model_out();
         checks++;
         if (obs !== exp) begin
            errors++; $display("FAIL int2_seq cyc %0d: got %b want %b", i, obs, exp);
         end
         if (int_vec_load) begin
            nvec++;
            checks++;
            if (int_vec_sel !== 1'b1 || i != D + 3) begin
               errors++; $display("FAIL int2_vec cyc %0d: sel %b want 1 at cyc %0d", i, int_vec_sel, D + 3);
            end
         end
         advance();
         int2 = 0;
      end
      checks++;
      if (nvec != 1) begin
         errors++; $display("FAIL int2_vec_count: got %0d want 1", nvec);
      end
   endtask

   task automatic test_both_ints();
      logic [8:0] exp;
      int sels[$];
      clear_inputs();
      int1 = 1; int2 = 1;
      for (int i = 0; i < 2 * (D + 4) + 3; i++) begin
         @(negedge clk);
         exp = model_out();
         checks++;
         if (obs !== exp) begin
            errors++; $display("FAIL both_ints cyc %0d: got %b want %b", i, obs, exp);
         end
         if (int_vec_load) sels.push_back(int'(int_vec_sel));
         advance();
         int1 = 0;
         if (i == D + 2) int2 = 0;
      end
      checks++;
      if (sels.size() != 2 || sels[0] != 0 || sels[1] != 1) begin
         errors++; $display("FAIL both_ints_order: got %0d vectors, want sel 0 then 1", sels.size());
      end
   endtask

   task automatic test_reset_mid();
      logic [8:0] exp;
      clear_inputs();
      int1 = 1;
      advance();
      int1 = 0;
      for (int i = 0; i < D; i++) advance();
      @(negedge clk);
      exp = model_out();
      checks++;
      if (obs !== exp || int_push_pc !== 1'b1) begin
         errors++; $display("FAIL mid_push_pc: got %b want %b", obs, exp);
      end
      #2 reset = 0;
      #1;
      checks++;
      if (obs !== 9'd0) begin
         errors++; $display("FAIL mid_reset_async: got %b want 0", obs);
      end
      for (int i = 0; i < 2; i++) begin
         advance();
         @(negedge clk);
         exp = model_out();
         checks++;
         if (obs !== exp || int_push_flags !== 1'b0) begin
            errors++; $display("FAIL mid_reset_hold cyc %0d: got %b want %b", i, obs, exp);
         end
      end
      advance();
      reset = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         exp = model_out();
         checks++;
         if (obs !== exp || int_busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset_idle cyc %0d: got %b want %b", i, obs, exp);
         end
         advance();
      end
   endtask

   task automatic test_stats();
      logic [2*CW-1:0] expc;
      clear_inputs();
      for (int i = 0; i < 6; i++) begin
         clear_inputs();
         if (i < 4) begin
            ex_mem_read = 1; ex_rd = AW'(i); id_rd = AW'(i); id_rd_used = 1;
         end else begin
            branch_taken = 1;
         end
         advance();
      end
      clear_inputs();
      @(negedge clk);
      expc = model_cnts();
      checks++;
      if ({stall_cnt, flush_cnt} !== expc) begin
         errors++; $display("FAIL stats: got %h want %h", {stall_cnt, flush_cnt}, expc);
      end
`ifdef HAZARD_STATS_EN
      checks++;
      if (stall_cnt !== CW'(SAT) || flush_cnt !== CW'(2)) begin
         errors++; $display("FAIL stats_sat: stall %0d flush %0d want %0d and 2", stall_cnt, flush_cnt, SAT);
      end
`endif
      advance();
   endtask

   task automatic test_random();
      logic [8:0]      exp;
      logic [2*CW-1:0] expc;
      for (int i = 0; i < 400; i++) begin
         id_rs        = AW'($urandom_range(0, 7));
         id_rd        = AW'($urandom_range(0, 7));
         ex_rd        = AW'($urandom_range(0, 7));
         id_rs_used   = ($urandom_range(0, 1) == 1);
         id_rd_used   = ($urandom_range(0, 1) == 1);
         ex_mem_read  = ($urandom_range(0, 1) == 1);
         branch_taken = ($urandom_range(0, 4) == 0);
         int1         = ($urandom_range(0, 11) == 0);
         int2         = ($urandom_range(0, 11) == 0);
         reset        = ($urandom_range(0, 99) != 0);
         @(negedge clk);
         exp  = model_out();
         expc = model_cnts();
         checks++;
         if (obs !== exp) begin
            errors++; $display("FAIL random_out cyc %0d: got %b want %b", i, obs, exp);
         end
         checks++;
         if ({stall_cnt, flush_cnt} !== expc) begin
            errors++; $display("FAIL random_cnt cyc %0d: got %h want %h", i, {stall_cnt, flush_cnt}, expc);
         end
         advance();
      end
      reset = 1;
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_int2_seq();
      test_both_ints();
      test_reset_mid();
      test_stats();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
